// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serializer: state encoding, default width
// and the parity helper used when PISO_TX_PARITY_EN is defined.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam int PISO_WIDTH = 4;

  // Even parity bit: makes the total count of ones (word + bit) even.
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// Clearable up-counter with a terminal-count flag at WIDTH-1; clear wins over en.
module piso_bitcnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign tc = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, LSB first, gap-free back-to-back words.
// Optional trailing even-parity bit and sout_par port under `PISO_TX_PARITY_EN.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
`ifdef PISO_TX_PARITY_EN
  output logic             sout_par,
`endif
  output logic             done
);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] cnt_s;
  logic             tc_s;
  logic             last_s;
  logic             accept_s;
  logic             cnt_en_s;

  assign last_s   = (state_r == ST_SHIFT) && tc_s;
  assign accept_s = load_valid && load_ready;
  // Saturating guard keeps the counter from ever passing WIDTH-1.
  assign cnt_en_s = (state_r == ST_SHIFT) && (cnt_s < CNT_W'(WIDTH - 1));

  piso_bitcnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (accept_s || last_s),
    .en    (cnt_en_s),
    .cnt   (cnt_s),
    .tc    (tc_s)
  );

`ifdef PISO_TX_PARITY_EN
  logic par_r;

  assign done       = (state_r == ST_PARITY);
  assign load_ready = (state_r == ST_IDLE) || (state_r == ST_PARITY);
  assign sout       = (state_r == ST_PARITY) ? par_r : shreg_r[0];
  assign sout_valid = (state_r == ST_SHIFT) || (state_r == ST_PARITY);
  assign sout_par   = (state_r == ST_PARITY);

  // Parity latched from the word at accept time
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      par_r <= 1'b0;
    end else if (accept_s) begin
      par_r <= even_parity(16'(din));
    end else begin
      par_r <= par_r;
    end
  end
`else
  assign done       = last_s;
  assign load_ready = (state_r == ST_IDLE) || last_s;
  assign sout       = shreg_r[0];
  assign sout_valid = (state_r == ST_SHIFT);
`endif

  assign busy = (state_r != ST_IDLE);

  // Next-state selection; an accept always (re)starts a data frame
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_SHIFT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
        end else if (last_s) begin
`ifdef PISO_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_IDLE;
`endif
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        if (accept_s) state_nxt_s = ST_SHIFT;
        else          state_nxt_s = ST_IDLE;
      end
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register: load on accept, shift right with zero fill while shifting
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      shreg_r <= din;
    end else if (state_r == ST_SHIFT) begin
      shreg_r <= shreg_r >> 1;
    end else begin
      shreg_r <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: queue-of-expected-bits reference model,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_piso_tx;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, sout, sout_valid, busy, done;
`ifdef PISO_TX_PARITY_EN
  logic         sout_par;
`endif

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
`ifdef PISO_TX_PARITY_EN
    .sout_par   (sout_par),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit serial-in stage: new bit enters at MSB, shifts right.
  logic [W-1:0] ds_q = '0;
  always @(posedge clk) ds_q <= {sout, ds_q[W-1:1]};

  // One entry per future output cycle: bit value, frame-final flag, parity flag.
  typedef struct {
    logic b;
    logic last;
    logic par;
  } ent_t;
  ent_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check this cycle's outputs, then advance the model across one clk edge.
  task automatic step();
    logic m_ready, m_accept, m_live;
    ent_t e;
    @(negedge clk);
    m_live  = (exp_q.size() != 0);
    m_ready = !m_live || exp_q[0].last;
    chk("sout_valid", W'(sout_valid), W'(m_live));
    chk("busy",       W'(busy),       W'(m_live));
    chk("load_ready", W'(load_ready), W'(m_ready));
    chk("sout",       W'(sout),       W'(m_live ? exp_q[0].b : 1'b0));
    chk("done",       W'(done),       W'(m_live ? exp_q[0].last : 1'b0));
`ifdef PISO_TX_PARITY_EN
    chk("sout_par",   W'(sout_par),   W'(m_live ? exp_q[0].par : 1'b0));
`endif
    m_accept = clr_n && load_valid && m_ready;
    @(posedge clk);
    if (!clr_n) begin
      exp_q.delete();
    end else begin
      if (m_live) void'(exp_q.pop_front());
      if (m_accept) begin
        for (int i = 0; i < W; i++) begin
          e.b = din[i]; e.last = !PAR && (i == W - 1); e.par = 1'b0;
          exp_q.push_back(e);
        end
        if (PAR) begin
          e.b = ^din; e.last = 1'b1; e.par = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    // Reset held with a word offered: nothing may be accepted.
    clr_n = 1'b0; load_valid = 1'b1; din = 4'hE;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step();
    clr_n = 1'b1; load_valid = 1'b0;
    step();

    // Single word 1011; downstream stage must hold it after the frame.
    din = 4'b1011; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) step();
`ifndef PISO_TX_PARITY_EN
    chk("downstream_q", ds_q, 4'b1011);
`endif
    for (int i = 0; i < 2; i++) step();

    // Back-to-back A then 5 with load_valid held.
    din = 4'hA; load_valid = 1'b1;
    step();
    din = 4'h5;
    for (int i = 0; i < W; i++) step();
    load_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) step();

    // din changes mid-frame are ignored.
    din = 4'h3; load_valid = 1'b1;
    step();
    load_valid = 1'b0; din = 4'hF;
    for (int i = 0; i < W + 2; i++) step();

    // Reset after two bits of C, then a clean 9.
    din = 4'hC; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step(); step();
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    step();
    din = 4'h9; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) step();

    // Parity vector 0111 (plain data frame when parity is compiled out).
    din = 4'b0111; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) step();

    // Randomized traffic with sporadic resets.
    for (int i = 0; i < 400; i++) begin
      din        = W'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      clr_n      = ($urandom_range(0, 50) != 0);
      step();
    end
    clr_n = 1'b1; load_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
